// File: rtl/conv_pkg.sv
// Shared widths and types for the row padding stage and the window generator.
//   IMG_W    unpadded row width in pixels
//   PIX_W    bits per pixel per channel
//   PAD_W    padded row width (one pad pixel each side)
//   WIN_PIX  pixels in one 3x3 window
//   ROW_BITS / WIN_BITS  flattened vector widths for one channel
package conv_pkg;

   localparam int IMG_W    = 416;
   localparam int PIX_W    = 8;
   localparam int PAD_W    = IMG_W + 2;
   localparam int WIN_PIX  = 9;
   localparam int COL_W    = 9;
   localparam int ROW_BITS = PAD_W * PIX_W;
   localparam int WIN_BITS = WIN_PIX * PIX_W;

   typedef enum logic {
      LOAD  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   typedef logic [COL_W-1:0] col_t;

endpackage

// File: rtl/win_slice.sv
// Column extractor: picks three adjacent pixels (col, col+1, col+2) out of a
// flattened padded row. Pixel col lands in the least significant byte.
//   row  in   padded row, pixel p at [PIX_W*p +: PIX_W]
//   col  in   leftmost column of the 3-pixel group
//   pix  out  {pixel col+2, pixel col+1, pixel col}
module win_slice
   import conv_pkg::*;
#(
   parameter int P_PIX_W = PIX_W,
   parameter int P_PAD_W = PAD_W,
   parameter int P_COL_W = COL_W
) (
   input  logic [P_PAD_W*P_PIX_W-1:0] row,
   input  logic [P_COL_W-1:0]         col,
   output logic [3*P_PIX_W-1:0]       pix
);

   // col never exceeds PAD_W-3 while a window is presented, so the
   // three-pixel part-select always stays inside the row.
   assign pix = row[P_PIX_W*col +: 3*P_PIX_W];

endmodule

// File: rtl/conv_window_gen.sv
// 3x3 RGB window generator. Holds the three most recent padded rows and
// sweeps a 3x3 window across them, one column per handshake.
//   clk, reset            clock, async active-low reset
//   row_valid/row_ready   padded row handshake, row_sof marks frame start
//   R_row, G_row, B_row   padded rows, pixel p at [PIX_W*p +: PIX_W]
//   win_valid/win_ready   window handshake
//   win_R, win_G, win_B   window bytes, k = 3*r + c, r=0 oldest row
//   win_col, win_last     window column, last column of the sweep
//
// state | meaning
// ------+------------------------------------------------------------
// LOAD  | waiting for rows; row_ready=1, accept shifts the row buffer
// SWEEP | presenting windows col 0..IMG_W-1; rows are not accepted
module conv_window_gen
   import conv_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                row_valid,
   output logic                row_ready,
   input  logic                row_sof,
   input  logic [ROW_BITS-1:0] R_row,
   input  logic [ROW_BITS-1:0] G_row,
   input  logic [ROW_BITS-1:0] B_row,
   output logic                win_valid,
   input  logic                win_ready,
   output logic [WIN_BITS-1:0] win_R,
   output logic [WIN_BITS-1:0] win_G,
   output logic [WIN_BITS-1:0] win_B,
   output logic [COL_W-1:0]    win_col,
   output logic                win_last
);

   state_t state, state_nxt;
   logic [1:0] fill, fill_nxt;
   col_t col, col_nxt;
   logic accept;
   logic last_col;

   // rb[channel][row]: row 0 oldest, row 2 newest; channel 0=R, 1=G, 2=B
   logic [ROW_BITS-1:0] rb     [3][3];
   logic [ROW_BITS-1:0] row_in [3];
   logic [3*PIX_W-1:0]  slc    [3][3];

   assign row_in[0] = R_row;
   assign row_in[1] = G_row;
   assign row_in[2] = B_row;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= LOAD;
         fill  <= 2'd0;
         col   <= '0;
      end else begin
         state <= state_nxt;
         fill  <= fill_nxt;
         col   <= col_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int ch = 0; ch < 3; ch++) begin
            for (int r = 0; r < 3; r++) begin
               rb[ch][r] <= '0;
            end
         end
      end else if (accept) begin
         for (int ch = 0; ch < 3; ch++) begin
            rb[ch][0] <= rb[ch][1];
            rb[ch][1] <= rb[ch][2];
            rb[ch][2] <= row_in[ch];
         end
      end
   end

   always_comb begin
      accept    = row_valid && (state == LOAD);
      last_col  = (col == col_t'(IMG_W-1));
      fill_nxt  = fill;
      state_nxt = state;
      col_nxt   = col;

      // A start-of-frame row always restarts the fill, even from a full buffer.
      if (accept) begin
         if (row_sof) begin
            fill_nxt = 2'd1;
         end else if (fill != 2'd3) begin
            fill_nxt = fill + 2'd1;
         end
      end

      case (state)
         LOAD: begin
            col_nxt = '0;
            if (accept && (fill_nxt == 2'd3)) begin
               state_nxt = SWEEP;
            end
         end
         SWEEP: begin
            if (win_ready) begin
               if (last_col) begin
                  col_nxt   = '0;
                  state_nxt = LOAD;
               end else begin
                  col_nxt = col + col_t'(1);
               end
            end
         end
      endcase
   end

   assign row_ready = (state == LOAD);
   assign win_valid = (state == SWEEP);
   assign win_last  = win_valid && last_col;
   assign win_col   = col;

   for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      for (genvar r = 0; r < 3; r++) begin : g_row
         win_slice #(
            .P_PIX_W(PIX_W),
            .P_PAD_W(PAD_W),
            .P_COL_W(COL_W)
         ) u_slice (
            .row(rb[ch][r]),
            .col(col),
            .pix(slc[ch][r])
         );
      end
   end

   assign win_R = {slc[0][2], slc[0][1], slc[0][0]};
   assign win_G = {slc[1][2], slc[1][1], slc[1][0]};
   assign win_B = {slc[2][2], slc[2][1], slc[2][0]};

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;
   import conv_pkg::*;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                row_valid = 1'b0;
   logic                row_ready;
   logic                row_sof = 1'b0;
   logic [ROW_BITS-1:0] tb_R = '0;
   logic [ROW_BITS-1:0] tb_G = '0;
   logic [ROW_BITS-1:0] tb_B = '0;
   logic                win_valid;
   logic                win_ready = 1'b0;
   logic [WIN_BITS-1:0] win_R, win_G, win_B;
   logic [COL_W-1:0]    win_col;
   logic                win_last;

   int tests = 0;
   int fails = 0;

   conv_window_gen dut (
      .clk(clk), .reset(reset),
      .row_valid(row_valid), .row_ready(row_ready), .row_sof(row_sof),
      .R_row(tb_R), .G_row(tb_G), .B_row(tb_B),
      .win_valid(win_valid), .win_ready(win_ready),
      .win_R(win_R), .win_G(win_G), .win_B(win_B),
      .win_col(win_col), .win_last(win_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: last three accepted rows, fill level, sweep position.
   logic [ROW_BITS-1:0] m_rows [3][3];
   int  m_fill = 0;
   bit  m_sweep = 1'b0;
   int  m_col = 0;

   initial begin
      for (int ch = 0; ch < 3; ch++)
         for (int r = 0; r < 3; r++)
            m_rows[ch][r] = '0;
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_sweep <= 1'b0;
         m_col   <= 0;
         m_fill  <= 0;
         for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 3; r++)
               m_rows[ch][r] <= '0;
      end else if (!m_sweep) begin
         if (row_valid) begin
            m_rows[0][0] <= m_rows[0][1]; m_rows[0][1] <= m_rows[0][2]; m_rows[0][2] <= tb_R;
            m_rows[1][0] <= m_rows[1][1]; m_rows[1][1] <= m_rows[1][2]; m_rows[1][2] <= tb_G;
            m_rows[2][0] <= m_rows[2][1]; m_rows[2][1] <= m_rows[2][2]; m_rows[2][2] <= tb_B;
            m_fill <= row_sof ? 1 : ((m_fill >= 3) ? 3 : m_fill + 1);
            if (!row_sof && m_fill >= 2) begin
               m_sweep <= 1'b1;
               m_col   <= 0;
            end
         end
      end else if (win_ready) begin
         if (m_col == IMG_W - 1) begin
            m_sweep <= 1'b0;
            m_col   <= 0;
         end else begin
            m_col <= m_col + 1;
         end
      end
   end

   function automatic logic [71:0] model_win(input int ch, input int c);
      logic [71:0] res;
      logic [ROW_BITS-1:0] rowv;
      res = '0;
      for (int k = 0; k < 9; k++) begin
         rowv = m_rows[ch][k / 3];
         res[k*8 +: 8] = rowv[(c + (k % 3)) * 8 +: 8];
      end
      return res;
   endfunction

   always @(negedge clk) begin
      check("win_valid", 72'(win_valid), 72'(m_sweep));
      check("row_ready", 72'(row_ready), 72'(!m_sweep));
      if (m_sweep) begin
         check("win_col", 72'(win_col), 72'(m_col));
         check("win_last", 72'(win_last), 72'(m_col == IMG_W - 1));
         check("win_R", win_R, model_win(0, m_col));
         check("win_G", win_G, model_win(1, m_col));
         check("win_B", win_B, model_win(2, m_col));
      end
   end

   // mode 0: p mod 256, mode 1: constant val, mode 2: (3p+val) mod 256
   function automatic logic [ROW_BITS-1:0] mk_row(input int mode, input int val);
      logic [ROW_BITS-1:0] r;
      r = '0;
      for (int p = 0; p < PAD_W; p++) begin
         case (mode)
            0:       r[p*8 +: 8] = 8'(p % 256);
            1:       r[p*8 +: 8] = 8'(val);
            default: r[p*8 +: 8] = 8'((3 * p + val) % 256);
         endcase
      end
      return r;
   endfunction

   // Called at a negedge; returns at the negedge following the accept edge.
   task automatic send_row(input logic [ROW_BITS-1:0] r, input logic [ROW_BITS-1:0] g,
                           input logic [ROW_BITS-1:0] b, input logic sof);
      int n = 0;
      while (!row_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!row_ready) begin
         check("row_ready_timeout", 72'(row_ready), 72'd1);
      end
      tb_R = r; tb_G = g; tb_B = b;
      row_sof = sof;
      row_valid = 1'b1;
      @(negedge clk);
      row_valid = 1'b0;
      row_sof = 1'b0;
   endtask

   // Called at a negedge with a window presented; returns at the first
   // negedge with win_valid low. Optionally stalls two cycles at stall_col+1.
   task automatic run_sweep(input int stall_col, output int nwin, output int nlast,
                            output logic [71:0] last_r);
      int cyc = 0;
      bit stalled = 1'b0;
      nwin = 0;
      nlast = 0;
      last_r = '0;
      win_ready = 1'b1;
      while (win_valid && cyc < 1500) begin
         if (stall_col >= 0 && !stalled && win_col == COL_W'(stall_col + 1)) begin
            stalled = 1'b1;
            win_ready = 1'b0;
            for (int s = 0; s < 2; s++) begin
               @(negedge clk);
               cyc++;
               check("stall_col", 72'(win_col), 72'(stall_col + 1));
               check("stall_pix", 72'(win_R[7:0]), 72'(stall_col + 1));
            end
            win_ready = 1'b1;
         end
         nwin++;
         if (win_last) begin
            nlast++;
            last_r = win_R;
         end
         @(negedge clk);
         cyc++;
      end
      check("sweep_done", 72'(win_valid), 72'd0);
   endtask

   int nwin, nlast;
   logic [71:0] last_r;
   logic [ROW_BITS-1:0] ra, ga, ba, rc, gc, bc;

   initial begin
      ra = mk_row(0, 0); ga = mk_row(2, 1); ba = mk_row(2, 7);
      rc = mk_row(1, 8'hAA); gc = mk_row(1, 8'h11); bc = mk_row(1, 8'h22);

      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_row_ready", 72'(row_ready), 72'd1);
      check("rst_win_valid", 72'(win_valid), 72'd0);
      check("rst_win_last", 72'(win_last), 72'd0);
      check("rst_win_col", 72'(win_col), 72'd0);
      check("rst_win_R", win_R, 72'd0);
      check("rst_win_G", win_G, 72'd0);
      check("rst_win_B", win_B, 72'd0);
      reset = 1'b1;
      @(negedge clk);

      // First sweep: three identical rows, held with win_ready low at col 0
      win_ready = 1'b0;
      send_row(ra, ga, ba, 1'b1);
      send_row(ra, ga, ba, 1'b0);
      check("fill2_no_valid", 72'(win_valid), 72'd0);
      send_row(ra, ga, ba, 1'b0);
      check("first_valid", 72'(win_valid), 72'd1);
      check("first_col", 72'(win_col), 72'd0);
      check("first_R", win_R, 72'h02_01_00_02_01_00_02_01_00);
      check("first_G", win_G, 72'h07_04_01_07_04_01_07_04_01);
      check("first_row_ready", 72'(row_ready), 72'd0);
      run_sweep(100, nwin, nlast, last_r);
      check("sweep1_count", 72'(nwin), 72'd416);
      check("sweep1_last_count", 72'(nlast), 72'd1);
      check("sweep1_last_R", last_r, 72'hA1A09F_A1A09F_A1A09F);
      check("sweep1_row_ready_after", 72'(row_ready), 72'd1);

      // Fourth row shifts the buffer
      win_ready = 1'b0;
      send_row(rc, gc, bc, 1'b0);
      check("row4_valid", 72'(win_valid), 72'd1);
      check("row4_top", 72'(win_R[71:48]), 72'hAAAAAA);
      check("row4_bottom", 72'(win_R[23:0]), 72'h020100);
      run_sweep(-1, nwin, nlast, last_r);
      check("sweep2_count", 72'(nwin), 72'd416);

      // Start-of-frame with a full buffer restarts filling
      win_ready = 1'b0;
      send_row(mk_row(1, 8'h55), mk_row(1, 8'h66), mk_row(1, 8'h77), 1'b1);
      check("sof_no_sweep", 72'(win_valid), 72'd0);
      send_row(ra, ga, ba, 1'b0);
      check("sof_plus1_no_sweep", 72'(win_valid), 72'd0);
      send_row(rc, gc, bc, 1'b0);
      check("sof_plus2_sweep", 72'(win_valid), 72'd1);
      check("sof_top_row", 72'(win_R[23:0]), 72'h555555);

      // Reset mid-sweep at col 200
      win_ready = 1'b1;
      for (int i = 0; i < 1000 && win_col != COL_W'(200); i++) @(negedge clk);
      check("reach_col200", 72'(win_col), 72'd200);
      #2 reset = 1'b0;
      #1;
      check("midrst_row_ready", 72'(row_ready), 72'd1);
      check("midrst_win_valid", 72'(win_valid), 72'd0);
      check("midrst_win_col", 72'(win_col), 72'd0);
      check("midrst_win_last", 72'(win_last), 72'd0);
      check("midrst_win_R", win_R, 72'd0);
      check("midrst_win_B", win_B, 72'd0);
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      send_row(ra, ga, ba, 1'b0);
      send_row(rc, gc, bc, 1'b0);
      check("post_rst_fill2", 72'(win_valid), 72'd0);
      send_row(ra, ga, ba, 1'b0);
      check("post_rst_fill3", 72'(win_valid), 72'd1);
      check("post_rst_R", win_R, 72'h02_01_00_AA_AA_AA_02_01_00);
      run_sweep(-1, nwin, nlast, last_r);
      check("sweep3_count", 72'(nwin), 72'd416);
      check("sweep3_last_count", 72'(nlast), 72'd1);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
